// File: rtl/vga_scan_driver_if.sv
// Pixel-side bundle of the VGA scan driver: raster position and strobes out
// to the renderer, color back in, and the registered DAC/sync pins.
interface vga_scan_driver_if;
  logic [23:0] color_data;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pix_en;
  logic        frame_start;
  logic        frame_clk;
  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  // Scan driver side: owns the raster, consumes color.
  modport master (
    input  color_data,
    output DrawX, DrawY, pix_en, frame_start, frame_clk,
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    output VGA_R, VGA_G, VGA_B
  );

  // Renderer / display side.
  modport slave (
    output color_data,
    input  DrawX, DrawY, pix_en, frame_start, frame_clk,
    input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    input  VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_scan_driver.sv
// VGA raster generator: divides Clk down to a pixel strobe, walks DrawX/DrawY
// over the full H/V totals, and registers sync/blank/color for the DAC one
// pixel (plus COLOR_LAT) behind the scan position.
module vga_scan_driver #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int COLOR_LAT = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  vga_scan_driver_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  // Elaboration-time guards on the parameter ranges the timing relies on.
  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("vga_scan_driver: CLK_DIV must be >= 2");
    end
    if (COLOR_LAT < 0 || COLOR_LAT > 3) begin : g_bad_lat
      $error("vga_scan_driver: COLOR_LAT must be 0..3");
    end
  endgenerate

  // Sync/visibility decode of one raster position, carried down the delay pipe.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } scan_t;

  logic [DW-1:0] div_cnt;
  logic          pix_en;
  logic [9:0]    draw_x;
  logic [9:0]    draw_y;
  scan_t         raw;
  scan_t         dly_out;
  logic          hs_n;
  logic          vs_n;
  logic          blank_n;
  logic [23:0]   rgb;

  // Pixel strobe is decoded straight from the divider so it lines up with
  // the edge that advances the counters.
  assign pix_en = (div_cnt == DIV_LAST);

  // Clock divider: counts 0..CLK_DIV-1 and wraps on the strobe.
  always_ff @(posedge Clk) begin
    if (!Reset)      div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + DW'(1);
  end

  // Raster counters: DrawX across the line, DrawY bumps on line wrap.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      draw_x <= '0;
      draw_y <= '0;
    end else if (pix_en) begin
      if (draw_x == H_LAST) begin
        draw_x <= '0;
        draw_y <= (draw_y == V_LAST) ? '0 : draw_y + 10'd1;
      end else begin
        draw_x <= draw_x + 10'd1;
      end
    end
  end

  // Raw decode of the current scan position (active-high sync flags).
  always_comb begin
    raw     = '0;
    raw.hs  = (draw_x >= HS_FIRST) && (draw_x <= HS_LAST);
    raw.vs  = (draw_y >= VS_FIRST) && (draw_y <= VS_LAST);
    raw.vis = (draw_x < X_VIS) && (draw_y < Y_VIS);
  end

  // Delay sync/visibility by COLOR_LAT pixels so they meet the color that the
  // renderer returns late; cleared to blank/inactive on reset.
  generate
    if (COLOR_LAT == 0) begin : g_no_dly
      assign dly_out = raw;
    end else begin : g_dly
      scan_t [COLOR_LAT-1:0] dly_pipe;

      // Shift one stage per pixel strobe.
      always_ff @(posedge Clk) begin
        if (!Reset) begin
          dly_pipe <= '0;
        end else if (pix_en) begin
          dly_pipe[0] <= raw;
          for (int i = 1; i < COLOR_LAT; i++) dly_pipe[i] <= dly_pipe[i-1];
        end
      end

      assign dly_out = dly_pipe[COLOR_LAT-1];
    end
  endgenerate

  // DAC output register: loads once per pixel, color gated to zero in blanking.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hs_n    <= 1'b1;
      vs_n    <= 1'b1;
      blank_n <= 1'b0;
      rgb     <= '0;
    end else if (pix_en) begin
      hs_n    <= ~dly_out.hs;
      vs_n    <= ~dly_out.vs;
      blank_n <= dly_out.vis;
      rgb     <= dly_out.vis ? vga.color_data : 24'h0;
    end
  end

  assign vga.DrawX       = draw_x;
  assign vga.DrawY       = draw_y;
  assign vga.pix_en      = pix_en;
  assign vga.frame_start = pix_en && (draw_x == H_LAST) && (draw_y == V_LAST);
  assign vga.VGA_CLK     = (div_cnt >= DIV_HALF);
  assign vga.VGA_HS      = hs_n;
  assign vga.VGA_VS      = vs_n;
  assign vga.frame_clk   = vs_n;
  assign vga.VGA_BLANK_N = blank_n;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_R       = rgb[23:16];
  assign vga.VGA_G       = rgb[15:8];
  assign vga.VGA_B       = rgb[7:0];

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: a full-size 640x480 instance (CLK_DIV=2,
// COLOR_LAT=0) and a shrunken-raster instance (CLK_DIV=3, COLOR_LAT=2) so
// whole frames fit in a short run. Expected outputs come from an arithmetic
// model: clock edges since reset -> pixel index -> (x,y) -> sync/blank/color.
module tb_vga_scan_driver;

  logic clk;
  logic rst;
  int   e;        // Clk edges since reset release (0 while in reset)
  int   cyc;
  int   errors;
  int   checks;
  logic [23:0] salt;

  vga_scan_driver_if if0 ();
  vga_scan_driver_if if1 ();

  vga_scan_driver dut0 (
    .Clk   (clk),
    .Reset (rst),
    .vga   (if0)
  );

  vga_scan_driver #(
    .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (6),
    .V_VISIBLE (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .CLK_DIV   (3),  .COLOR_LAT (2)
  ) dut1 (
    .Clk   (clk),
    .Reset (rst),
    .vga   (if1)
  );

  logic [51:0] obs [2];
  assign obs[0] = {if0.DrawX, if0.DrawY, if0.pix_en, if0.frame_start, if0.frame_clk, if0.VGA_CLK,
                   if0.VGA_HS, if0.VGA_VS, if0.VGA_BLANK_N, if0.VGA_SYNC_N, if0.VGA_R, if0.VGA_G, if0.VGA_B};
  assign obs[1] = {if1.DrawX, if1.DrawY, if1.pix_en, if1.frame_start, if1.frame_clk, if1.VGA_CLK,
                   if1.VGA_HS, if1.VGA_VS, if1.VGA_BLANK_N, if1.VGA_SYNC_N, if1.VGA_R, if1.VGA_G, if1.VGA_B};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pixel color the renderer would produce for (x,y).
  function automatic logic [23:0] colorf(input int x, input int y, input logic [23:0] s);
    return s ^ 24'((y << 14) + (x << 4) + 5);
  endfunction

  // Renderer: returns the color of the position COLOR_LAT pixels behind the scan.
  function automatic logic [23:0] drive_color(input int ht, input int vt, input int div,
                                              input int lat, input int ee);
    int tot, q;
    tot = ht * vt;
    q   = ee / div - lat;
    q   = ((q % tot) + tot) % tot;
    return colorf(q % ht, q / ht, salt);
  endfunction

  // Expected packed outputs after ee edges since reset release.
  function automatic logic [51:0] model(input int hv, input int hf, input int hs, input int hb,
                                        input int vv, input int vf, input int vs, input int vb,
                                        input int div, input int lat, input int ee);
    int ht, vt, tot, n, ph, x, y, p, px, py;
    logic pe, fs, hsn, vsn, bn;
    logic [23:0] rgb;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    tot = ht * vt;
    n   = ee / div;
    ph  = ee % div;
    x   = n % ht;
    y   = (n / ht) % vt;
    pe  = (ph == div - 1);
    fs  = pe && (x == ht - 1) && (y == vt - 1);
    p   = n - 1 - lat;
    if (p < 0) begin
      hsn = 1'b1; vsn = 1'b1; bn = 1'b0; rgb = 24'h0;
    end else begin
      p   = p % tot;
      px  = p % ht;
      py  = p / ht;
      hsn = !(px >= hv + hf && px < hv + hf + hs);
      vsn = !(py >= vv + vf && py < vv + vf + vs);
      bn  = (px < hv) && (py < vv);
      rgb = bn ? colorf(px, py, salt) : 24'h0;
    end
    return {10'(x), 10'(y), pe, fs, vsn, (ph >= div / 2), hsn, vsn, bn, 1'b0, rgb};
  endfunction

  function automatic logic [51:0] exp_of(input int d, input int ee);
    if (d == 0) return model(640, 16, 96, 48, 480, 10, 2, 33, 2, 0, ee);
    else        return model(16, 4, 6, 6, 8, 2, 2, 3, 3, 2, ee);
  endfunction

  // One Clk edge; then present the renderer's color for the new position.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst) e = 0;
    else      e++;
    #1;
    if0.color_data = drive_color(800, 525, 2, 0, e);
    if1.color_data = drive_color(32, 15, 3, 2, e);
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    salt = 24'($urandom);
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== exp_of(d, 0)) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h exp %h", d, obs[d], exp_of(d, 0));
      end
    end
    checks++;
    if ({if0.VGA_HS, if0.VGA_VS, if0.frame_clk, if0.VGA_BLANK_N, if0.VGA_R, if0.VGA_G, if0.VGA_B, if0.DrawX}
        !== {4'b1110, 24'h0, 10'd0}) begin
      errors++;
      $display("FAIL reset_pins dut0 got hs=%b vs=%b blank_n=%b x=%0d exp hs=1 vs=1 blank_n=0 x=0",
               if0.VGA_HS, if0.VGA_VS, if0.VGA_BLANK_N, if0.DrawX);
    end
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (if0.pix_en !== 1'((k % 2) == 1) || if0.DrawX !== 10'(k / 2)) begin
        errors++;
        $display("FAIL release_strobe k=%0d got pix_en=%b x=%0d exp pix_en=%0d x=%0d",
                 k, if0.pix_en, if0.DrawX, k % 2, k / 2);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_of(d, e)) begin
          errors++;
          $display("FAIL release dut%0d e=%0d got %h exp %h", d, e, obs[d], exp_of(d, e));
        end
      end
    end
  endtask

  task automatic test_visible_line();
    repeat (2000) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_of(d, e)) begin
          errors++;
          $display("FAIL visible dut%0d e=%0d got %h exp %h", d, e, obs[d], exp_of(d, e));
        end
      end
    end
  endtask

  task automatic test_hsync();
    int lo0, lo1, fall0, rise0, fall1, rise1;
    logic p0, p1;
    lo0 = 0; lo1 = 0; fall0 = -1; rise0 = -1; fall1 = -1; rise1 = -1;
    p0 = if0.VGA_HS; p1 = if1.VGA_HS;
    for (int k = 0; k < 1600; k++) begin
      step();
      if (!if0.VGA_HS) lo0++;
      if (k < 96 && !if1.VGA_HS) lo1++;
      if (p0 && !if0.VGA_HS) fall0 = int'(if0.DrawX);
      if (!p0 && if0.VGA_HS) rise0 = int'(if0.DrawX);
      if (p1 && !if1.VGA_HS) fall1 = int'(if1.DrawX);
      if (!p1 && if1.VGA_HS) rise1 = int'(if1.DrawX);
      p0 = if0.VGA_HS; p1 = if1.VGA_HS;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_of(d, e)) begin
          errors++;
          $display("FAIL hsync_scan dut%0d e=%0d got %h exp %h", d, e, obs[d], exp_of(d, e));
        end
      end
    end
    checks++;
    if (lo0 != 96 * 2) begin errors++; $display("FAIL hs_width dut0 got %0d clk exp %0d", lo0, 192); end
    checks++;
    if (lo1 != 6 * 3) begin errors++; $display("FAIL hs_width dut1 got %0d clk exp %0d", lo1, 18); end
    checks++;
    if (fall0 != 657 || rise0 != 753) begin
      errors++; $display("FAIL hs_place dut0 got fall@%0d rise@%0d exp 657/753", fall0, rise0);
    end
    checks++;
    if (fall1 != 23 || rise1 != 29) begin
      errors++; $display("FAIL hs_place dut1 got fall@%0d rise@%0d exp 23/29", fall1, rise1);
    end
  endtask

  task automatic test_frame();
    int t1, t2, vlo, vis, budget;
    t1 = -1; t2 = -1; vlo = 0; vis = 0; budget = 0;
    while (t1 < 0 && budget < 2000) begin
      step(); budget++;
      if (if1.frame_start) t1 = cyc;
    end
    budget = 0;
    while (t1 >= 0 && t2 < 0 && budget < 2000) begin
      step(); budget++;
      if (!if1.VGA_VS) vlo++;
      if (if1.VGA_BLANK_N) vis++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_of(d, e)) begin
          errors++;
          $display("FAIL frame_scan dut%0d e=%0d got %h exp %h", d, e, obs[d], exp_of(d, e));
        end
      end
      if (if1.frame_start) t2 = cyc;
    end
    checks++;
    if (t1 < 0 || t2 < 0 || t2 - t1 != 32 * 15 * 3) begin
      errors++; $display("FAIL frame_period dut1 got %0d clk exp %0d", t2 - t1, 1440);
    end
    checks++;
    if (vlo != 2 * 32 * 3) begin errors++; $display("FAIL vs_width dut1 got %0d clk exp %0d", vlo, 192); end
    checks++;
    if (vis != 16 * 8 * 3) begin errors++; $display("FAIL visible_area dut1 got %0d clk exp %0d", vis, 384); end
  endtask

  task automatic test_reset_midframe();
    int tn, budget, hs_glitch;
    tn = int'($urandom_range(40, 470));
    budget = 0;
    while (!((e / 3) % 480 == tn && e % 3 == 0) && budget < 2000) begin
      step(); budget++;
    end
    checks++;
    if (budget >= 2000) begin errors++; $display("FAIL midframe_reach got timeout exp pixel %0d", tn); end
    rst  = 1'b0;
    salt = 24'($urandom);
    step();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== exp_of(d, 0)) begin
        errors++;
        $display("FAIL midframe_reset dut%0d got %h exp %h", d, obs[d], exp_of(d, 0));
      end
    end
    hs_glitch = 0;
    for (int k = 0; k < 1500; k++) begin
      step();
      if (k < 60 && (!if1.VGA_HS || !if1.VGA_VS)) hs_glitch++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_of(d, e)) begin
          errors++;
          $display("FAIL midframe_scan dut%0d e=%0d got %h exp %h", d, e, obs[d], exp_of(d, e));
        end
      end
    end
    checks++;
    if (hs_glitch != 0) begin errors++; $display("FAIL partial_sync dut1 got %0d low clk exp 0", hs_glitch); end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      rst  = 1'b0;
      salt = 24'($urandom);
      repeat (int'($urandom_range(1, 3))) step();
      rst = 1'b1;
      repeat (int'($urandom_range(100, 600))) begin
        step();
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (obs[d] !== exp_of(d, e)) begin
            errors++;
            $display("FAIL b2b dut%0d it=%0d e=%0d got %h exp %h", d, it, e, obs[d], exp_of(d, e));
          end
        end
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0; e = 0; cyc = 0;
    rst = 1'b0; salt = 24'h0;
    if0.color_data = 24'h0;
    if1.color_data = 24'h0;
    test_reset();
    test_visible_line();
    test_hsync();
    test_frame();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
